// File: rtl/uart_cfg_ctrl.sv
// Configuration-frame decoder: parses HDR/ADDR/DH/DL/CHK frames from the UART
// receive path and issues register writes, with an inter-byte timeout.
module uart_cfg_ctrl #(
    parameter int         TIMEOUT_CYC = 200000,
    parameter logic [7:0] HDR_BYTE    = 8'hA5,
    parameter logic [7:0] END_ADDR    = 8'hFF
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_vld,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_addr,
    output logic [15:0] o_wr_dat,
    output logic        o_err,
    output logic [7:0]  o_frm_cnt,
    output logic        o_rx_cfg_over
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DH, DL, CHK} state_t;

    // Asynchronous assert, synchronous release of the internal reset.
    logic rst_meta_q, rst_sync_q;
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d, dh_q, dh_d, dl_q, dl_d;
    logic             wr_en_q, wr_en_d, err_q, err_d, cfg_over_q, cfg_over_d;
    logic [7:0]       wr_addr_q, wr_addr_d, frm_cnt_q, frm_cnt_d;
    logic [15:0]      wr_dat_q, wr_dat_d;
    logic [7:0]       sum;

    assign sum = 8'(addr_q + dh_q + dl_q);

    always_ff @(posedge clk_ref or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            dh_q       <= '0;
            dl_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_dat_q   <= '0;
            err_q      <= 1'b0;
            frm_cnt_q  <= '0;
            cfg_over_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dh_q       <= dh_d;
            dl_q       <= dl_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_dat_q   <= wr_dat_d;
            err_q      <= err_d;
            frm_cnt_q  <= frm_cnt_d;
            cfg_over_q <= cfg_over_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dh_d       = dh_q;
        dl_d       = dl_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_dat_d   = wr_dat_q;
        err_d      = 1'b0;
        frm_cnt_d  = frm_cnt_q;
        cfg_over_d = cfg_over_q;

        if (state_q != IDLE) cnt_d = cnt_q + 1'b1;

        // An arriving byte always beats a timeout on the same cycle.
        if (i_rx_vld) begin
            cnt_d = '0;
            case (state_q)
                IDLE: if (i_rx_dat == HDR_BYTE) state_d = ADDR;
                ADDR: begin addr_d = i_rx_dat; state_d = DH; end
                DH:   begin dh_d = i_rx_dat;   state_d = DL; end
                DL:   begin dl_d = i_rx_dat;   state_d = CHK; end
                CHK: begin
                    state_d = IDLE;
                    if (i_rx_dat == sum) begin
                        frm_cnt_d = frm_cnt_q + 8'd1;
                        if (addr_q == END_ADDR) begin
                            cfg_over_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_dat_d  = {dh_q, dl_q};
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_dat      = wr_dat_q;
    assign o_err         = err_q;
    assign o_frm_cnt     = frm_cnt_q;
    assign o_rx_cfg_over = cfg_over_q;

endmodule
